// File: rtl/wb_merge_stage.sv
// wb_merge_stage
//   Write-back merge stage. Merges in-order execute results and variable-latency
//   load returns onto the single register-file write port. A load that loses
//   arbitration waits in a small in-order queue. A queued load is cancelled
//   (kill bit) when a younger execute result targets the same register.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   ex_valid/RW/MD/DA   execute result qualifiers and destination
//   F_out, N_xor_V      execute result value and less-than flag
//   mem_valid/mem_ready load return handshake
//   memData, mem_DA     load return data and destination
//   writeData/Reg/Enable registered register-file write port
//   pending             queue holds at least one entry
//
// Optional feature macro: WB_BYPASS_EN
//   Adds byp_addr/byp_hit/byp_data so decode can forward the value on the
//   write port this cycle.
module wb_merge_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] F_out,
  input  logic              N_xor_V,
  input  logic [ADDR_W-1:0] DA,
  input  logic              RW,
  input  logic [1:0]        MD,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [DATA_W-1:0] memData,
  input  logic [ADDR_W-1:0] mem_DA,
  output logic [DATA_W-1:0] writeData,
  output logic [ADDR_W-1:0] writeReg,
  output logic              writeEnable,
  output logic              pending
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0] byp_addr,
  output logic              byp_hit,
  output logic [DATA_W-1:0] byp_data
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_q_data [DEPTH];
  logic [ADDR_W-1:0] r_q_da   [DEPTH];
  logic [DEPTH-1:0]  r_q_kill;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic              w_e;
  logic [DATA_W-1:0] w_ex_data;
  logic              w_empty;
  logic              w_accept;
  logic              w_pop;
  logic              w_direct;
  logic              w_push;
  logic              w_push_kill;
  logic [DATA_W-1:0] w_head_data;
  logic [ADDR_W-1:0] w_head_da;
  logic              w_head_kill;

  assign w_e       = ex_valid & RW & (MD != 2'b01) & (DA != '0);
  assign w_ex_data = (MD == 2'b10) ? {{(DATA_W-1){1'b0}}, N_xor_V} : F_out;

  assign w_empty   = (r_count == '0);
  assign mem_ready = ~reset & (r_count < FULL_CNT);
  assign pending   = ~w_empty;

  // Arbitration: execute first, then queue head, then a direct load. A direct
  // load is only legal with an empty queue so load writes stay in return order.
  assign w_accept    = mem_valid & mem_ready;
  assign w_pop       = ~w_e & ~w_empty;
  assign w_direct    = ~w_e & w_empty & w_accept & (mem_DA != '0);
  // Loads to register 0 are accepted but dropped here.
  assign w_push      = w_accept & (mem_DA != '0) & ~w_direct;
  assign w_push_kill = w_e & (mem_DA == DA);

  assign w_head_data = r_q_data[r_rd_ptr];
  assign w_head_da   = r_q_da[r_rd_ptr];
  assign w_head_kill = r_q_kill[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_data[r_wr_ptr] <= memData;
      r_q_da[r_wr_ptr]   <= mem_DA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_kill <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Kill marking may touch free slots too; harmless, since a push always
      // rewrites the kill bit of the slot it fills (the later assignment wins).
      for (int i = 0; i < DEPTH; i++) begin
        if (w_e && (r_q_da[i] == DA)) r_q_kill[i] <= 1'b1;
      end
      if (w_push) begin
        r_q_kill[r_wr_ptr] <= w_push_kill;
        r_wr_ptr           <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Write address/data only move on an actual write; they hold otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      writeEnable <= 1'b0;
      writeData   <= '0;
      writeReg    <= '0;
    end else begin
      writeEnable <= 1'b0;
      if (w_e) begin
        writeEnable <= 1'b1;
        writeReg    <= DA;
        writeData   <= w_ex_data;
      end else if (w_pop) begin
        if (!w_head_kill && (w_head_da != '0)) begin
          writeEnable <= 1'b1;
          writeReg    <= w_head_da;
          writeData   <= w_head_data;
        end
      end else if (w_direct) begin
        writeEnable <= 1'b1;
        writeReg    <= mem_DA;
        writeData   <= memData;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_hit  = writeEnable & (writeReg == byp_addr) & (byp_addr != '0);
  assign byp_data = byp_hit ? writeData : '0;
`endif

endmodule

// File: doc/wb_merge_stage.md
# wb_merge_stage

Parametrised write-back stage that merges two result sources onto the single register-file write port: in-order execute results, and load data returning from memory with variable latency. Load returns that lose arbitration are held in a small in-order queue. Stale queued loads are cancelled when a younger execute result targets the same register. Sits between the execute/memory stages and the register file; its outputs drive the register-file write port directly.

## Interface
Parameters:
- DATA_W, 32, register/data width
- ADDR_W, 5, register address width (register 0 is hardwired zero)
- DEPTH, 4, load-return queue entries (power of 2, ≥2)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- ex_valid  in  1  execute result present this cycle
- F_out  in  DATA_W  function-unit result
- N_xor_V  in  1  less-than flag
- DA  in  ADDR_W  execute destination register
- RW  in  1  execute write request
- MD  in  2  00/11 = F_out; 10 = zero-extended N_xor_V; 01 = load (no execute-path write)
- mem_valid  in  1  load data returning
- mem_ready  out  1  load return accepted this cycle when high with mem_valid
- memData  in  DATA_W  returned load data
- mem_DA  in  ADDR_W  load destination register
- writeData  out  DATA_W  register-file write data (registered)
- writeReg  out  ADDR_W  register-file write address (registered)
- writeEnable  out  1  register-file write strobe (registered)
- pending  out  1  queue non-empty

## Operation
- Execute write request (E): ex_valid & RW & MD≠01 & DA≠0.
- Each cycle exactly one source is selected, in this priority:
  - E: writes the MD-selected value to DA.
  - Queue head: pop.
  - Direct load: mem_valid & queue empty & mem_DA≠0.
  - Otherwise writeEnable=0 next cycle.
- Load acceptance: mem_valid & mem_ready. An accepted load not written directly is pushed. Loads with mem_DA=0 are accepted and discarded, never pushed.
- mem_ready = !reset & (count<DEPTH). It is combinational from registered count only; there is no dependence on mem_valid.
- Simultaneous push and pop are allowed when count<DEPTH: count is unchanged and order is preserved.
- Ordering: queue is strict FIFO. Direct load is only allowed when the queue is empty, so load writes commit in return order.
- Kill rule: when E fires, every valid queue entry whose DA equals the E DA has its kill bit set. A load pushed in the same cycle with mem_DA equal to the E DA is pushed with kill=1.
- Killed entries still pop in order and consume their slot, but produce writeEnable=0.
- Writes never target register 0: E, direct, and pop paths all suppress DA/mem_DA=0.
- Reset: queue emptied, kill bits cleared, writeEnable=0, writeData=0, writeReg=0, pending=0. Reset mid-operation discards all queued loads.

## Timing
- Latency: 1 cycle from selection to writeEnable/writeData/writeReg.
- The register file sees a write one edge after those outputs are valid.
- Loads from execute-cycle arbitration to write: 1 cycle if direct, otherwise 1 cycle after reaching queue head with no E present.
- Sustained E every cycle starves the queue. Loads back-pressure via mem_ready once DEPTH entries are held.
- pending reflects registered count (count≠0).

## Configuration
- WB_BYPASS_EN defined: adds ports byp_addr in ADDR_W, byp_hit out 1, byp_data out DATA_W.
  - byp_hit = writeEnable & writeReg==byp_addr & byp_addr≠0, combinational.
  - byp_data = writeData when byp_hit, else 0.
  - This lets decode forward the value being written this cycle.
- WB_BYPASS_EN undefined: these ports and the logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold reset 3 cycles with mem_valid=1 -> mem_ready=0, writeEnable=0, writeData=0, pending=0; no push.
- Execute path: F_out=A5A5A5A5, DA=5, RW=1, MD=00 -> next cycle writeEnable=1, writeReg=5, writeData=A5A5A5A5. Repeat with MD=10, N_xor_V=1, DA=15 -> writeData=00000001.
- Collision: E (DA=3, data 11111111) and load (mem_DA=7, 22222222) same cycle -> E written first, pending=1. Next cycle writes reg 7 = 22222222, pending=0.
- Back-pressure (DEPTH=4): continuous E plus 5 loads -> mem_ready falls after 4 accepts. On E idle, the 4 queued loads write in acceptance order. The 5th is then accepted.
- Kill: queue load to reg 9 behind E traffic, then E writes reg 9 = DEADBEEF -> queued entry pops with writeEnable=0, so reg 9 ends DEADBEEF. A load with mem_DA=0 produces no write.
- Reset mid-queue: 3 queued loads, assert reset 1 cycle -> pending=0, no further writes. With WB_BYPASS_EN, byp_addr=5 during the write of reg 5 -> byp_hit=1, byp_data=writeData.
